iris_argmax: RTL and testbench
==============================

Name: iris_argmax

Overview:
- Classification stage directly downstream of the Iris network output layer.
- Captures the NUM_CLASSES signed linear-activation neuron outputs when the layer signals completion.
- Scans them sequentially to find the winning class, its score and the margin over the runner-up.
- Presents the result on a valid/ack handshake to the result consumer (display, UART or testbench scoreboard).

Parameters:
- DATA_WIDTH, 8: neuron data width; each score is DATA_WIDTH+6 bits signed, matching neuron Y outputs.
- NUM_CLASSES, 3: number of output neurons; must be >= 2.
- CLASS_W, 2: width of class index; must satisfy 2**CLASS_W >= NUM_CLASSES.
- MARGIN_TH, 0: low-confidence threshold; LowConf asserted when Margin <= MARGIN_TH.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- En  in  1  clock enable; when low, all registers hold (async reset still acts).
- Start  in  1  one-cycle pulse, output layer results are stable on Y_in.
- Y_in  in  NUM_CLASSES*(DATA_WIDTH+6)  packed signed scores; class k at bits [(k+1)*(DATA_WIDTH+6)-1 : k*(DATA_WIDTH+6)].
- Ack  in  1  consumer accepts the result.
- Valid  out  1  result available, held until Ack.
- Class  out  CLASS_W  index of the maximum score.
- Score  out  DATA_WIDTH+6  signed winning score.
- Margin  out  DATA_WIDTH+7  unsigned best minus second-best score.
- LowConf  out  1  Margin <= MARGIN_TH.
- Busy  out  1  state != IDLE.
- Overrun  out  1  sticky; a Start arrived while not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. Valid, Class, Score, Margin, LowConf, Busy and Overrun are all 0. Internal best/second/index registers are cleared.
- All state and data updates are qualified by En=1.
- States: IDLE, COMPARE, RESULT, HOLD.
- IDLE, Start=1:
  - Latch Y_in into an internal score buffer.
  - best <= score[0], best_idx <= 0, second <= most-negative (DATA_WIDTH+6)-bit value, idx <= 1.
  - Go to COMPARE.
- IDLE, Start=0: stay in IDLE.
- COMPARE, one element per cycle, s = score[idx]:
  - If s > best (signed, strict): second <= best, best <= s, best_idx <= idx.
  - Else if s > second: second <= s.
  - If idx == NUM_CLASSES-1, go to RESULT; otherwise idx <= idx+1.
- RESULT:
  - Margin <= best - second, computed sign-extended to DATA_WIDTH+7 bits; never negative, never overflows.
  - Class <= best_idx, Score <= best, LowConf <= (Margin value <= MARGIN_TH).
  - Valid <= 1. Go to HOLD.
- HOLD:
  - Outputs are frozen.
  - Ack=1: Valid <= 0, go to IDLE.
  - Ack=0: stay in HOLD.
  - Class, Score, Margin and LowConf keep their last values after Ack, until the next RESULT.
- Latency: Start sampled at edge 0. COMPARE occupies edges 1..NUM_CLASSES-1. RESULT edge NUM_CLASSES sets Valid. With default parameters, Valid is high after edge 3.
- Ties: strict compare, so the lowest index wins. Margin = 0 on a tie for best.
- Start while state != IDLE (including the same cycle as Ack in HOLD):
  - Start is ignored; buffer and outputs are unaffected.
  - Overrun <= 1; cleared only by reset.
- Ack outside HOLD: ignored.
- En low mid-scan: the scan pauses and resumes with identical results once En returns high.
- Reset mid-operation: immediate return to IDLE with all outputs 0. A result in progress is discarded.
- Y_in is only sampled on the Start edge. Changes afterwards do not affect the result.

Test Plan:
- Reset, then Start with Y_in = {y0=20, y1=-5, y2=35} → Valid rises after edge 3; Class=2, Score=35, Margin=15, LowConf=0, Busy=1 during edges 1-3 and HOLD.
- Y_in = {10, 10, 3} → Class=0, Score=10, Margin=0, LowConf=1 (MARGIN_TH=0).
- Y_in = {-40, -12, -30} → Class=1, Score=-12, Margin=18. Repeat with {8191, -8192, -8192} → Class=0, Margin=16383 (no overflow).
- Hold Ack=0 for 10 cycles after Valid and pulse Start at cycle 5 → Valid stays 1, outputs unchanged, Overrun=1. Ack=1 → Valid=0 next edge, state IDLE, Overrun still 1.
- Drop En for 4 cycles during COMPARE with {1, 7, 2}, and change Y_in meanwhile → result still Class=1, Score=7, Margin=5, Valid delayed by exactly 4 cycles.
- Assert rst=0 asynchronously during COMPARE → Valid, Busy and all outputs 0 immediately. A fresh Start after release yields the correct result for the new Y_in.

Source files
------------

// File: rtl/iris_argmax.sv
// Output-layer argmax: captures NUM_CLASSES signed scores on Start, scans them
// one per cycle, and holds winner/score/margin on a valid/ack handshake.
module iris_argmax #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_CLASSES = 3,
  parameter int CLASS_W     = 2,
  parameter int MARGIN_TH   = 0
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     En,
  input  logic                                     Start,
  input  logic [NUM_CLASSES*(DATA_WIDTH+6)-1:0]    Y_in,
  input  logic                                     Ack,
  output logic                                     Valid,
  output logic [CLASS_W-1:0]                       Class,
  output logic signed [DATA_WIDTH+5:0]             Score,
  output logic [DATA_WIDTH+6:0]                    Margin,
  output logic                                     LowConf,
  output logic                                     Busy,
  output logic                                     Overrun
);
  localparam int SW = DATA_WIDTH + 6;
  localparam int MW = DATA_WIDTH + 7;
  localparam logic [CLASS_W-1:0] LAST = CLASS_W'(NUM_CLASSES - 1);
  localparam logic signed [SW-1:0] MOST_NEG = {1'b1, {(SW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_RESULT, S_HOLD} state_t;

  state_t                    r_state, w_next;
  logic signed [SW-1:0]      r_score [NUM_CLASSES];
  logic signed [SW-1:0]      r_best, r_second;
  logic [CLASS_W-1:0]        r_best_idx, r_idx;
  logic signed [SW-1:0]      w_s;
  logic [MW-1:0]             w_margin;
  logic signed [31:0]        w_margin_ext;
  logic                      w_lowconf;

  assign w_s          = r_score[r_idx];
  // Both operands sign-extended by one bit, so the difference can never wrap.
  assign w_margin     = {r_best[SW-1], r_best} - {r_second[SW-1], r_second};
  assign w_margin_ext = 32'(w_margin);
  assign w_lowconf    = (w_margin_ext <= MARGIN_TH);
  assign Busy         = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    r_state <= S_IDLE;
    else if (En) r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (Start) w_next = S_COMPARE;
      S_COMPARE: if (r_idx == LAST) w_next = S_RESULT;
      S_RESULT:  w_next = S_HOLD;
      S_HOLD:    if (Ack) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_CLASSES; k++) r_score[k] <= '0;
      r_best     <= '0;
      r_second   <= '0;
      r_best_idx <= '0;
      r_idx      <= '0;
      Valid      <= 1'b0;
      Class      <= '0;
      Score      <= '0;
      Margin     <= '0;
      LowConf    <= 1'b0;
      Overrun    <= 1'b0;
    end else if (En) begin
      // A Start outside IDLE is dropped but remembered until reset.
      if (Start && r_state != S_IDLE) Overrun <= 1'b1;
      case (r_state)
        S_IDLE: if (Start) begin
          for (int k = 0; k < NUM_CLASSES; k++) r_score[k] <= Y_in[k*SW +: SW];
          r_best     <= Y_in[SW-1:0];
          r_best_idx <= '0;
          r_second   <= MOST_NEG;
          r_idx      <= CLASS_W'(1);
        end
        S_COMPARE: begin
          if (w_s > r_best) begin
            r_second   <= r_best;
            r_best     <= w_s;
            r_best_idx <= r_idx;
          end else if (w_s > r_second) begin
            r_second <= w_s;
          end
          if (r_idx != LAST) r_idx <= r_idx + CLASS_W'(1);
        end
        S_RESULT: begin
          Margin  <= w_margin;
          Class   <= r_best_idx;
          Score   <= r_best;
          LowConf <= w_lowconf;
          Valid   <= 1'b1;
        end
        S_HOLD: if (Ack) Valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_iris_argmax.sv
// Directed bench for iris_argmax: table of score vectors plus hand-written
// overrun, clock-enable pause and asynchronous reset sequences.
module tb_iris_argmax;
  localparam int DW = 8;
  localparam int NC = 3;
  localparam int CW = 2;
  localparam int SW = DW + 6;
  localparam int MW = DW + 7;

  logic                 clk, rst, En, Start, Ack;
  logic [NC*SW-1:0]     Y_in;
  logic                 Valid, LowConf, Busy, Overrun;
  logic [CW-1:0]        Class;
  logic signed [SW-1:0] Score;
  logic [MW-1:0]        Margin;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int y0, y1, y2;
    int cls, score, margin, lowconf;
  } vec_t;

  vec_t v [7];

  iris_argmax #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .CLASS_W(CW), .MARGIN_TH(0)) dut (
    .clk(clk), .rst(rst), .En(En), .Start(Start), .Y_in(Y_in), .Ack(Ack),
    .Valid(Valid), .Class(Class), .Score(Score), .Margin(Margin),
    .LowConf(LowConf), .Busy(Busy), .Overrun(Overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic start_vec(input int a, input int b, input int c);
    Y_in  = {14'(c), 14'(b), 14'(a)};
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!Valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (!Valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic check_res(input string tag, input vec_t t);
    chk({tag, "_valid"},   int'(Valid), 1);
    chk({tag, "_busy"},    int'(Busy), 1);
    chk({tag, "_class"},   int'(Class), t.cls);
    chk({tag, "_score"},   int'(Score), t.score);
    chk({tag, "_margin"},  int'(Margin), t.margin);
    chk({tag, "_lowconf"}, int'(LowConf), t.lowconf);
  endtask

  task automatic do_ack(input string tag, input vec_t t);
    Ack = 1'b1;
    @(negedge clk);
    Ack = 1'b0;
    chk({tag, "_ack_valid"}, int'(Valid), 0);
    chk({tag, "_ack_busy"},  int'(Busy), 0);
    chk({tag, "_ack_class_kept"}, int'(Class), t.cls);
    chk({tag, "_ack_score_kept"}, int'(Score), t.score);
  endtask

  initial begin
    int   lat;
    vec_t e;
    vec_t r;

    v[0] = '{20, -5, 35, 2, 35, 15, 0};
    v[1] = '{10, 10, 3, 0, 10, 0, 1};
    v[2] = '{-40, -12, -30, 1, -12, 18, 0};
    v[3] = '{8191, -8192, -8192, 0, 8191, 16383, 0};
    v[4] = '{3, 9, 9, 1, 9, 0, 1};
    v[5] = '{-8192, -8192, -8192, 0, -8192, 0, 1};
    v[6] = '{-1, 0, 1, 2, 1, 1, 0};

    rst = 1'b0; En = 1'b1; Start = 1'b0; Ack = 1'b0; Y_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid",   int'(Valid), 0);
    chk("rst_class",   int'(Class), 0);
    chk("rst_score",   int'(Score), 0);
    chk("rst_margin",  int'(Margin), 0);
    chk("rst_lowconf", int'(LowConf), 0);
    chk("rst_busy",    int'(Busy), 0);
    chk("rst_overrun", int'(Overrun), 0);
    rst = 1'b1;
    @(negedge clk);

    foreach (v[i]) begin
      start_vec(v[i].y0, v[i].y1, v[i].y2);
      chk($sformatf("v%0d_busy_edge0", i), int'(Busy), 1);
      Y_in = '1;
      wait_valid(lat);
      chk($sformatf("v%0d_latency", i), lat, NC);
      check_res($sformatf("v%0d", i), v[i]);
      do_ack($sformatf("v%0d", i), v[i]);
    end
    chk("overrun_clear_before", int'(Overrun), 0);

    // Consumer stalls; a Start arrives mid-hold and must be ignored.
    start_vec(v[0].y0, v[0].y1, v[0].y2);
    wait_valid(lat);
    chk("ovr_latency", lat, NC);
    for (int c = 0; c < 10; c++) begin
      if (c == 5) begin
        Y_in  = {14'(1), 14'(2), 14'(3)};
        Start = 1'b1;
      end else begin
        Start = 1'b0;
      end
      @(negedge clk);
    end
    Start = 1'b0;
    check_res("ovr_hold", v[0]);
    chk("ovr_overrun", int'(Overrun), 1);
    do_ack("ovr", v[0]);
    chk("ovr_overrun_sticky", int'(Overrun), 1);

    // Clock enable dropped for 4 cycles after the first compare edge.
    e = '{1, 7, 2, 1, 7, 5, 0};
    start_vec(e.y0, e.y1, e.y2);
    @(negedge clk);
    En = 1'b0;
    Y_in = {14'(50), 14'(-100), 14'(100)};
    repeat (4) @(negedge clk);
    chk("en_paused_valid", int'(Valid), 0);
    chk("en_paused_busy",  int'(Busy), 1);
    En = 1'b1;
    wait_valid(lat);
    chk("en_remaining_latency", lat, 2);
    check_res("en", e);
    do_ack("en", e);

    // Asynchronous reset in the middle of a scan.
    start_vec(v[0].y0, v[0].y1, v[0].y2);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid",   int'(Valid), 0);
    chk("arst_busy",    int'(Busy), 0);
    chk("arst_class",   int'(Class), 0);
    chk("arst_score",   int'(Score), 0);
    chk("arst_margin",  int'(Margin), 0);
    chk("arst_lowconf", int'(LowConf), 0);
    chk("arst_overrun", int'(Overrun), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    r = v[2];
    start_vec(r.y0, r.y1, r.y2);
    wait_valid(lat);
    chk("post_rst_latency", lat, NC);
    check_res("post_rst", r);
    do_ack("post_rst", r);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
